// File: rtl/chan_router_pkg.sv
// Shared constants and elaboration helpers for the channel router.
// Pointer sizing and parameter legality live here so the FIFO and top agree.
package chan_router_pkg;

    localparam int DROP_W = 8;

    function automatic int clog2(input int value);
        return $clog2(value);
    endfunction

    // Legal when DEPTH is a power of two >= 2, CHANNELS is 2..16 and every channel has a select code.
    function automatic bit params_ok(input int depth, input int chans, input int selw);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (chans >= 2) && (chans <= 16) && ((1 << selw) >= chans);
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Small first-word-fall-through FIFO; the head word is presented whenever not empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module chan_fifo
    import chan_router_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush, doPop;

    assign empty  = (wrPtr_q == rdPtr_q);
    assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Head is forced to zero while empty so stale storage never shows on out_data.
    assign rdata = empty ? '0 : mem_q[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) wrPtr_d = wrPtr_q + {{AW{1'b0}}, 1'b1};
        if (doPop)  rdPtr_d = rdPtr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/chan_router.sv
// Steers each accepted word to one of CHANNELS buffered outputs by select code.
// Out-of-range codes are swallowed and counted; every accept is echoed on the monitor tap.
module chan_router
    import chan_router_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 2,
    parameter int SELW     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SELW-1:0]           in_sel,
    input  logic [WIDTH-1:0]          in_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      mon_valid,
    output logic [WIDTH-1:0]          mon_data,
    output logic [DROP_W-1:0]         drop_count
);

    if (!params_ok(DEPTH, CHANNELS, SELW)) begin : g_param_check
        $error("chan_router: illegal DEPTH/CHANNELS/SELW combination");
    end

    localparam logic [SELW:0] CHAN_L = (SELW+1)'(CHANNELS);

    logic [CHANNELS-1:0] full, empty, push;
    logic                inRange, selFull, accept;
    logic                monValid_q, monValid_d;
    logic [WIDTH-1:0]    monData_q, monData_d;
    logic [DROP_W-1:0]   dropCount_q, dropCount_d;

    assign inRange = ({1'b0, in_sel} < CHAN_L);

    always_comb begin
        selFull = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_sel == SELW'(c)) selFull = full[c];
        end
    end

    // Ready depends only on registered full flags, never on out_ready.
    assign in_ready = !rst && enable && (!inRange || !selFull);
    assign accept   = in_valid && in_ready;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign push[g] = accept && inRange && (in_sel == SELW'(g));

        chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (out_ready[g] && !empty[g]),
            .wdata (in_data),
            .rdata (out_data[g*WIDTH +: WIDTH]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    assign out_valid = ~empty;

    always_comb begin
        monValid_d  = accept;
        monData_d   = accept ? in_data : monData_q;
        dropCount_d = dropCount_q;
        if (accept && !inRange && (dropCount_q != '1)) dropCount_d = dropCount_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            monValid_q  <= 1'b0;
            monData_q   <= '0;
            dropCount_q <= '0;
        end else begin
            monValid_q  <= monValid_d;
            monData_q   <= monData_d;
            dropCount_q <= dropCount_d;
        end
    end

    assign mon_valid  = monValid_q;
    assign mon_data   = monData_q;
    assign drop_count = dropCount_q;

endmodule

// File: tb/tb_chan_router.sv
// Scoreboard bench for chan_router: per-channel expected queues are filled on accept
// and drained as each channel pops, with monitor and drop counter modelled alongside.
module tb_chan_router;

    localparam int WIDTH    = 5;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 2;
    localparam int SELW     = 4;

    logic                      clk;
    logic                      rst;
    logic                      enable;
    logic                      in_valid;
    logic                      in_ready;
    logic [SELW-1:0]           in_sel;
    logic [WIDTH-1:0]          in_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      mon_valid;
    logic [WIDTH-1:0]          mon_data;
    logic [7:0]                drop_count;

    chan_router #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .SELW     (SELW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .mon_valid  (mon_valid),
        .mon_data   (mon_data),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               assertCount = 0;
    int               failCount   = 0;
    logic [WIDTH-1:0] sbq [CHANNELS][$];
    logic             expMonValid = 1'b0;
    logic [WIDTH-1:0] expMonData  = '0;
    int               expDrop     = 0;
    logic             lastAccept  = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [SELW-1:0] sel, input logic [WIDTH-1:0] data);
        in_valid = valid;
        in_sel   = sel;
        in_data  = data;
    endtask

    // Called after a falling edge with inputs applied; models one rising edge.
    task automatic stepCycle();
        logic expReady;
        logic acc;
        #1;
        expReady = 1'b0;
        if (!rst && enable) begin
            if (int'(in_sel) >= CHANNELS) expReady = 1'b1;
            else expReady = (sbq[in_sel].size() < DEPTH);
        end
        checkOutput("in_ready", in_ready, expReady);
        acc = in_valid && expReady;
        for (int c = 0; c < CHANNELS; c++) begin
            checkOutput("out_valid", out_valid[c], sbq[c].size() != 0);
            if (sbq[c].size() != 0) begin
                checkOutput("out_data", out_data[c*WIDTH +: WIDTH], sbq[c][0]);
                if (out_ready[c] && !rst) void'(sbq[c].pop_front());
            end else begin
                checkOutput("out_data_idle", out_data[c*WIDTH +: WIDTH], 0);
            end
        end
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) sbq[c].delete();
            expMonValid = 1'b0;
            expMonData  = '0;
            expDrop     = 0;
        end else begin
            expMonValid = acc;
            if (acc) begin
                expMonData = in_data;
                if (int'(in_sel) < CHANNELS) sbq[in_sel].push_back(in_data);
                else if (expDrop < 255) expDrop++;
            end
        end
        lastAccept = acc;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mon_valid", mon_valid, expMonValid);
        checkOutput("mon_data", mon_data, expMonData);
        checkOutput("drop_count", drop_count, expDrop);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        out_ready = '0;
        applyStimulus(1'b0, '0, '0);
        @(negedge clk);

        // Reset state
        stepCycle();
        stepCycle();
        rst = 1'b0;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_mon_valid", mon_valid, 0);
        checkOutput("reset_drop", drop_count, 0);

        // Single word to channel 1
        enable = 1'b1;
        applyStimulus(1'b1, 4'd1, 5'd7);
        stepCycle();
        applyStimulus(1'b0, '0, '0);
        checkOutput("first_out_valid", out_valid, 4'b0010);
        checkOutput("first_ch1_data", out_data[1*WIDTH +: WIDTH], 7);
        checkOutput("first_mon", {mon_valid, mon_data}, {1'b1, 5'd7});
        out_ready = 4'b0010;
        stepCycle();
        out_ready = '0;

        // Fill channel 3, hold the blocked third word, then release
        applyStimulus(1'b1, 4'd3, 5'd10); stepCycle();
        applyStimulus(1'b1, 4'd3, 5'd11); stepCycle();
        applyStimulus(1'b1, 4'd3, 5'd12); stepCycle();
        checkOutput("ch3_full_block", lastAccept, 0);
        out_ready[3] = 1'b1;
        stepCycle();
        checkOutput("ch3_ready_after_pop", lastAccept, 0);
        stepCycle();
        checkOutput("ch3_ready_returns", lastAccept, 1);
        applyStimulus(1'b0, '0, '0);
        for (int i = 0; i < 4; i++) stepCycle();
        out_ready = '0;

        // Out-of-range drops saturate the counter
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 4'd9, 5'(i));
            stepCycle();
        end
        applyStimulus(1'b0, '0, '0);
        checkOutput("drop_saturated", drop_count, 255);
        checkOutput("drop_no_out_valid", out_valid, 0);

        // Disabled input while channel 0 drains
        applyStimulus(1'b1, 4'd0, 5'd21); stepCycle();
        enable = 1'b0;
        applyStimulus(1'b1, 4'd0, 5'd22);
        out_ready[0] = 1'b1;
        stepCycle();
        checkOutput("disabled_no_accept", lastAccept, 0);
        stepCycle();
        checkOutput("disabled_drained", out_valid[0], 0);
        applyStimulus(1'b0, '0, '0);
        enable    = 1'b1;
        out_ready = '0;

        // Push and pop together on channel 2 across pointer wrap
        applyStimulus(1'b1, 4'd2, 5'd0); stepCycle();
        out_ready[2] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 4'd2, 5'(i + 16));
            stepCycle();
            checkOutput("ch2_occupancy", out_valid[2], 1);
        end
        applyStimulus(1'b0, '0, '0);
        stepCycle();
        stepCycle();
        out_ready = '0;

        // Reset with data buffered in three channels
        applyStimulus(1'b1, 4'd0, 5'd1); stepCycle();
        applyStimulus(1'b1, 4'd1, 5'd2); stepCycle();
        applyStimulus(1'b1, 4'd3, 5'd3); stepCycle();
        applyStimulus(1'b1, 4'd12, 5'd4); stepCycle();
        applyStimulus(1'b0, '0, '0);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_drop", drop_count, 0);
        checkOutput("midreset_mon_valid", mon_valid, 0);
        stepCycle();

        // Random traffic, holding a stalled word until it is taken
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !lastAccept)) begin
                applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 5)), 5'($urandom));
            end
            enable    = ($urandom_range(0, 7) != 0);
            out_ready = 4'($urandom);
            stepCycle();
        end
        applyStimulus(1'b0, '0, '0);
        out_ready = '1;
        for (int i = 0; i < 4; i++) stepCycle();
        checkOutput("final_drained", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
